// File: rtl/alu_add_sub_pipe.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES registered segments, with valid/ready flow control.
// Optional signed saturation driven by i_sat is built only when ALU_ADD_SUB_SAT_EN is defined.
module alu_add_sub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_sat,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_zero,
  output logic             o_neg
);
  localparam int SEG = WIDTH / STAGES;

  logic              adv;
  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  b_in;

  assign o_valid = vld_q[STAGES-1];
  assign adv     = !o_valid || i_ready;
  assign o_ready = adv;
  assign b_in    = i_sub ? ~i_b : i_b;

`ifndef ALU_ADD_SUB_SAT_EN
  logic sat_unused;
  assign sat_unused = i_sat;
`endif

  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset)  vld_q <= '0;
    else if (adv)  vld_q <= STAGES'({vld_q, i_valid});

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // Each stage consumes the low SEG bits of what is left of the operands
    // and hands only the untouched upper bits down the pipe.
    localparam int SRC = WIDTH - k*SEG;
    localparam int REM = SRC - SEG;

    logic [SRC-1:0]         a_src, b_src;
    logic                   c_src;
    logic [SEG:0]           sum;
    logic [(k+1)*SEG-1:0]   r_d, r_nx, r_q;
    logic                   c_q;
`ifdef ALU_ADD_SUB_SAT_EN
    logic                   s_src;
`endif

    if (k == 0) begin : g_head
      assign a_src = i_a;
      assign b_src = b_in;
      assign c_src = i_sub;
      assign r_d   = sum[SEG-1:0];
`ifdef ALU_ADD_SUB_SAT_EN
      assign s_src = i_sat;
`endif
    end else begin : g_body
      assign a_src = g_stg[k-1].g_fwd.a_q;
      assign b_src = g_stg[k-1].g_fwd.b_q;
      assign c_src = g_stg[k-1].c_q;
      assign r_d   = {sum[SEG-1:0], g_stg[k-1].r_q};
`ifdef ALU_ADD_SUB_SAT_EN
      assign s_src = g_stg[k-1].g_fwd.s_q;
`endif
    end

    assign sum = {1'b0, a_src[SEG-1:0]} + {1'b0, b_src[SEG-1:0]} + {{SEG{1'b0}}, c_src};

    always_ff @(posedge i_clk or negedge i_reset)
      if (!i_reset) begin
        r_q <= '0;
        c_q <= 1'b0;
      end else if (adv) begin
        r_q <= r_nx;
        c_q <= sum[SEG];
      end

    if (REM > 0) begin : g_fwd
      logic [REM-1:0] a_q, b_q;
`ifdef ALU_ADD_SUB_SAT_EN
      logic           s_q;
`endif
      always_ff @(posedge i_clk or negedge i_reset)
        if (!i_reset) begin
          a_q <= '0;
          b_q <= '0;
`ifdef ALU_ADD_SUB_SAT_EN
          s_q <= 1'b0;
`endif
        end else if (adv) begin
          a_q <= a_src[SRC-1:SEG];
          b_q <= b_src[SRC-1:SEG];
`ifdef ALU_ADD_SUB_SAT_EN
          s_q <= s_src;
`endif
        end
    end

    if (k == STAGES-1) begin : g_tail
      logic ovf_d, ovf_q, z_q, n_q;
      // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
      assign ovf_d = sum[SEG] ^ (a_src[SEG-1] ^ b_src[SEG-1] ^ sum[SEG-1]);
`ifdef ALU_ADD_SUB_SAT_EN
      always_comb begin
        r_nx = r_d;
        if (s_src && ovf_d)
          r_nx = a_src[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
`else
      assign r_nx = r_d;
`endif
      always_ff @(posedge i_clk or negedge i_reset)
        if (!i_reset) begin
          ovf_q <= 1'b0;
          z_q   <= 1'b0;
          n_q   <= 1'b0;
        end else if (adv) begin
          ovf_q <= ovf_d;
          z_q   <= (r_nx == '0);
          n_q   <= r_nx[WIDTH-1];
        end
      assign o_result   = r_q;
      assign o_carry    = c_q;
      assign o_overflow = ovf_q;
      assign o_zero     = z_q;
      assign o_neg      = n_q;
    end else begin : g_mid
      assign r_nx = r_d;
    end
  end
endmodule

// File: tb/tb_alu_add_sub_pipe.sv
// Bench for alu_add_sub_pipe: directed literal vectors plus a queue-based arithmetic model,
// exercised on a 32/4 instance and on 8/1 and 64/8 instances.
module tb_alu_add_sub_pipe;
  typedef struct { logic [63:0] r; logic c, v, z, n; int t; } exp_t;

  logic clk = 0, rst_n = 1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0, nout = 0;

  logic iv = 0, sub = 0, sat = 0, ir = 1;
  logic [31:0] a = 0, b = 0, ores;
  logic ordy, ov, oc, oo, oz, on;

  logic ivs = 0, subs = 0, sats = 0, one = 1;
  logic [7:0]  a8 = 0, b8 = 0, r8;
  logic [63:0] a64 = 0, b64 = 0, r64;
  logic rdy8, v8, c8, o8, z8, n8, rdy64, v64, c64, o64, z64, n64;

  alu_add_sub_pipe #(.WIDTH(32), .STAGES(4)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_valid(iv), .o_ready(ordy), .i_a(a), .i_b(b),
    .i_sub(sub), .i_sat(sat), .o_valid(ov), .i_ready(ir), .o_result(ores),
    .o_carry(oc), .o_overflow(oo), .o_zero(oz), .o_neg(on));

  alu_add_sub_pipe #(.WIDTH(8), .STAGES(1)) dut8 (
    .i_clk(clk), .i_reset(rst_n), .i_valid(ivs), .o_ready(rdy8), .i_a(a8), .i_b(b8),
    .i_sub(subs), .i_sat(sats), .o_valid(v8), .i_ready(one), .o_result(r8),
    .o_carry(c8), .o_overflow(o8), .o_zero(z8), .o_neg(n8));

  alu_add_sub_pipe #(.WIDTH(64), .STAGES(8)) dut64 (
    .i_clk(clk), .i_reset(rst_n), .i_valid(ivs), .o_ready(rdy64), .i_a(a64), .i_b(b64),
    .i_sub(subs), .i_sat(sats), .o_valid(v64), .i_ready(one), .o_result(r64),
    .o_carry(c64), .o_overflow(o64), .o_zero(z64), .o_neg(n64));

  // Reference: plain integer arithmetic on the true operand values.
  function automatic exp_t model(int w, logic [63:0] a_, logic [63:0] b_, logic sub_, logic sat_, int t_);
    exp_t e;
    logic [64:0] mask;
    logic [66:0] u;
    logic signed [66:0] sa, sb, tr, half;
    mask = (65'd1 << w) - 65'd1;
    u = {2'b0, {1'b0, a_} & mask} +
        (sub_ ? ({2'b0, ~{1'b0, b_} & mask} + 67'd1) : {2'b0, {1'b0, b_} & mask});
    e.c = u[w];
    e.r = u[63:0] & mask[63:0];
    sa = $signed({3'b0, a_ & mask[63:0]});
    if (a_[w-1]) sa = sa - (67'sd1 <<< w);
    sb = $signed({3'b0, b_ & mask[63:0]});
    if (b_[w-1]) sb = sb - (67'sd1 <<< w);
    tr = sub_ ? sa - sb : sa + sb;
    half = 67'sd1 <<< (w - 1);
    e.v = (tr >= half) || (tr < -half);
`ifdef ALU_ADD_SUB_SAT_EN
    if (sat_ && e.v) e.r = (tr < 0) ? half[63:0] : half[63:0] - 64'd1;
`else
    if (sat_ && 1'b0) e.r = 64'd0;
`endif
    e.z = (e.r == 64'd0);
    e.n = e.r[w-1];
    e.t = t_;
    return e;
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  exp_t q[$], q8[$], q64[$];

  always @(negedge clk) begin : cmp
    exp_t e;
    if (!rst_n) begin
      chk("rst_valid", 64'(ov), 64'd0);
      chk("rst_out", 64'({ores, oc, oo, oz, on}), 64'd0);
      q.delete(); q8.delete(); q64.delete();
    end else begin
      chk("ready", 64'(ordy), 64'(!ov || ir));
      if (ov) begin
        if (q.size() == 0) chk("stale", 64'(ov), 64'd0);
        else begin
          chk("res", 64'(ores), q[0].r);
          chk("flags", 64'({oc, oo, oz, on}), 64'({q[0].c, q[0].v, q[0].z, q[0].n}));
          if (ir) begin void'(q.pop_front()); nout++; end
        end
      end
      if (iv && ordy) q.push_back(model(32, 64'(a), 64'(b), sub, sat, cyc));
      if (v8) begin
        if (q8.size() == 0) chk("s8_stale", 64'(v8), 64'd0);
        else begin
          e = q8.pop_front();
          chk("s8_res", 64'(r8), e.r);
          chk("s8_flags", 64'({c8, o8, z8, n8}), 64'({e.c, e.v, e.z, e.n}));
          chk("s8_lat", 64'(cyc - e.t), 64'd1);
        end
      end
      if (v64) begin
        if (q64.size() == 0) chk("s64_stale", 64'(v64), 64'd0);
        else begin
          e = q64.pop_front();
          chk("s64_res", r64, e.r);
          chk("s64_flags", 64'({c64, o64, z64, n64}), 64'({e.c, e.v, e.z, e.n}));
          chk("s64_lat", 64'(cyc - e.t), 64'd8);
        end
      end
      if (ivs && rdy8)  q8.push_back(model(8, 64'(a8), 64'(b8), subs, sats, cyc));
      if (ivs && rdy64) q64.push_back(model(64, a64, b64, subs, sats, cyc));
    end
  end

  // One op into an idle 32/4 pipe; result must appear in cycle 4.
  task automatic dir_op(string nm, logic [31:0] a_, logic [31:0] b_, logic sub_, logic sat_,
                        logic [31:0] er, logic [3:0] ef);
    int n;
    a = a_; b = b_; sub = sub_; sat = sat_; iv = 1;
    @(posedge clk); #1;
    iv = 0; n = 1;
    while (!ov && n < 20) begin @(posedge clk); #1; n++; end
    chk({nm, "_lat"}, 64'(n), 64'd4);
    chk({nm, "_res"}, 64'(ores), 64'(er));
    chk({nm, "_flg"}, 64'({oc, oo, oz, on}), 64'(ef));
  endtask

  initial begin : wdog
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    exp_t m;
    int sent, k, base;
    logic acc;

    m = model(8, 64'hFF, 64'h1, 1'b0, 1'b0, 0);
    chk("pin8_r", m.r, 64'd0);
    chk("pin8_f", 64'({m.c, m.v, m.z, m.n}), 64'b1010);
    m = model(64, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0);
    chk("pin64_r", m.r, 64'h8000_0000_0000_0000);
    chk("pin64_f", 64'({m.c, m.v, m.z, m.n}), 64'b0101);
    m = model(64, 64'h0, 64'h1, 1'b1, 1'b0, 0);
    chk("pin64s_r", m.r, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pin64s_f", 64'({m.c, m.v, m.z, m.n}), 64'b0001);

    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("ready_after_rst", 64'(ordy), 64'd1);

    dir_op("carry_all", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 4'b1010);
    dir_op("sub_neg", 32'd5, 32'd7, 1'b1, 1'b0, 32'hFFFF_FFFE, 4'b0001);
    dir_op("mixed", 32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0, 32'h2222_2221, 4'b0000);
    dir_op("sub_eq", 32'd3, 32'd3, 1'b1, 1'b0, 32'h0, 4'b1010);
`ifdef ALU_ADD_SUB_SAT_EN
    dir_op("ovf_add", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 4'b0100);
    dir_op("ovf_sub", 32'h8000_0000, 32'h1, 1'b1, 1'b1, 32'h8000_0000, 4'b1101);
`else
    dir_op("ovf_add", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 32'h8000_0000, 4'b0101);
    dir_op("ovf_sub", 32'h8000_0000, 32'h1, 1'b1, 1'b1, 32'h7FFF_FFFF, 4'b1100);
`endif
    @(posedge clk); #1;

    // Reset with ops in flight and the oldest one already at the output.
    iv = 1;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; sub = 1'(i); sat = 0;
      @(posedge clk); #1;
    end
    iv = 0;
    @(posedge clk); #1;
    rst_n = 0; #1;
    chk("rst_async_valid", 64'(ov), 64'd0);
    chk("rst_async_res", 64'(ores), 64'd0);
    @(posedge clk); #1;
    rst_n = 1;
    chk("ready_after_rst2", 64'(ordy), 64'd1);
    dir_op("post_rst", 32'd100, 32'd58, 1'b1, 1'b0, 32'd42, 4'b1000);
    @(posedge clk); #1;

    // Backpressure: 10 ops back to back, sink stalls for 5 cycles mid-stream.
    base = nout; sent = 0; k = 0;
    a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1)); sat = 1'($urandom_range(0, 1));
    iv = 1;
    while (sent < 10 && k < 100) begin
      ir = !(k >= 4 && k < 9);
      #1 acc = ordy;
      @(posedge clk); #1;
      k++;
      if (acc) begin
        sent++;
        a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1)); sat = 1'($urandom_range(0, 1));
      end
    end
    iv = 0; ir = 1;
    k = 0;
    while (q.size() != 0 && k < 50) begin @(posedge clk); #1; k++; end
    chk("bp_count", 64'(nout - base), 64'd10);

    // Throughput: 100 random ops at full rate on all three instances.
    base = nout;
    iv = 1; ivs = 1;
    for (int i = 0; i < 100; i++) begin
      a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1)); sat = 1'($urandom_range(0, 1));
      a8 = 8'($urandom); b8 = 8'($urandom); subs = 1'($urandom_range(0, 1)); sats = 1'($urandom_range(0, 1));
      a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    iv = 0; ivs = 0;
    repeat (12) @(posedge clk);
    #1;
    chk("tput_count", 64'(nout - base), 64'd100);
    chk("sweep_drained", 64'(q8.size() + q64.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_add_sub_pipe.md
Name: alu_add_sub_pipe

Overview:
- Parametrised, pipelined adder/subtractor. Successor to the single-cycle add/sub unit.
- Splits the WIDTH-bit carry chain into STAGES registered segments. Carry ripples stage to stage, so fmax scales with segment width.
- valid/ready handshake with full backpressure; sustained throughput of 1 op/cycle.
- Produces carry, signed overflow, zero and negative flags. Used by the multi-cycle/pipelined datapath for ADD/SUB/SLT/branch compare.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).
- STAGES, 4, number of pipeline segments (>=1). WIDTH must be divisible by STAGES; SEG = WIDTH/STAGES.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  input operation valid.
- o_ready  out  1  unit accepts input this cycle.
- i_a  in  WIDTH  operand A.
- i_b  in  WIDTH  operand B.
- i_sub  in  1  0 = A+B, 1 = A-B (A + ~B + 1).
- i_sat  in  1  saturate enable (used only with ALU_ADD_SUB_SAT_EN, ignored otherwise).
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_result  out  WIDTH  sum/difference.
- o_carry  out  1  carry out of MSB; for SUB, 1 = no borrow (A>=B unsigned).
- o_overflow  out  1  signed overflow (carry into MSB xor carry out of MSB).
- o_zero  out  1  o_result == 0.
- o_neg  out  1  o_result[WIDTH-1].

Behaviour:
- Reset (i_reset=0, any time, async):
  - All stage valid bits cleared.
  - o_valid=0; o_result, o_carry, o_overflow, o_zero, o_neg = 0.
  - In-flight ops discarded.
  - o_ready=1 on the first cycle after release.
- Global advance: adv = !o_valid | i_ready. o_ready = adv. All stage registers load only when adv=1, otherwise they hold. No bubbles are collapsed.
- Input transfer: i_valid & o_ready.
- Stage 0 setup: B' = i_sub ? ~i_b : i_b; carry-in = i_sub.
- Stage k (0..STAGES-1):
  - Adds bits [k*SEG +: SEG] of A and B' plus the carry from stage k-1 (stage 0: i_sub).
  - Registers the partial result, the upper unprocessed operand bits, the carry out, the valid bit, and the carry into the MSB (last stage only).
  - Upper operand bits and lower completed result bits are skewed/forwarded unchanged.
- Latency: exactly STAGES cycles from input transfer to o_valid, with no stalls. STAGES=1 gives a registered single-cycle unit.
- Stall behaviour:
  - o_valid=1 & i_ready=0: every output and internal register holds; o_ready=0.
  - Inputs offered during a stall are not captured.
- Ordering: results emerge in input order, one per transfer, never dropped or duplicated.
- Flags come from the final-stage registers: o_zero and o_neg are computed from o_result after optional saturation.
- Arithmetic wraps modulo 2^WIDTH. Examples: 0xFFFFFFFF+1 = 0, carry=1; 0x80000000-1 = 0x7FFFFFFF, overflow=1.
- Simultaneous i_valid on the cycle o_valid drains with i_ready=1: input accepted, pipeline advances, 1/cycle throughput.
- Empty pipeline with i_ready=0: adv=1 (o_valid=0), so inputs still fill the pipeline until a result reaches the output.

Optional Feature:
- ALU_ADD_SUB_SAT_EN defined:
  - i_sat is carried down the pipeline with each op.
  - At the final stage, if i_sat=1 and signed overflow: o_result = 0x7FF..F when the true result is positive (operand-A sign 0), else 0x800..0. o_overflow still reports 1.
  - i_sat=0 gives wrapping results.
- ALU_ADD_SUB_SAT_EN not defined: i_sat is unused, no saturation logic or register bit is generated, results always wrap.

Test Plan (WIDTH=32, STAGES=4 unless noted):
- Reset mid-stream: 3 ops in flight, assert i_reset=0 -> o_valid=0 immediately; after release, no stale result appears and the first new op emerges 4 cycles after its transfer.
- Carry across all segments: A=0xFFFFFFFF, B=1, sub=0 -> 4 cycles later result=0, carry=1, zero=1, overflow=0. SUB A=5, B=7 -> 0xFFFFFFFE, carry=0, neg=1.
- Signed overflow: A=0x7FFFFFFF+B=1 -> 0x80000000, overflow=1. A=0x80000000-B=1 -> 0x7FFFFFFF, overflow=1. With ALU_ADD_SUB_SAT_EN and i_sat=1 -> 0x7FFFFFFF and 0x80000000 respectively.
- Backpressure: stream 10 random ops back to back, hold i_ready=0 for 5 cycles mid-stream -> o_ready=0 while o_valid=1, outputs stable, all 10 results correct and in order.
- Throughput: i_ready=1 constantly, 100 random ops -> first o_valid 4 cycles after the first transfer, then one result per cycle, matching a reference model.
- Parameter sweep: WIDTH=8/STAGES=1 and WIDTH=64/STAGES=8 with random ADD/SUB -> latency = STAGES, and results/flags match the model.
